// File: rtl/multicycle_controller_pkg.sv
// Shared constants for the multi-cycle RISC-V controller: opcodes, state encodings, mux selects.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  // Encodings 11-15 are unused; S_JAL is only reachable when the jal feature is built in.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: master is the controller, slave is the datapath side.
interface multicycle_controller_if #(parameter int STATE_W = 4);
  logic [6:0]         op;
  logic               zero;
  logic               mem_ready;
  logic               PCWrite;
  logic               AdrSrc;
  logic               MemWrite;
  logic               IRWrite;
  logic               RegWrite;
  logic [1:0]         ResultSrc;
  logic [1:0]         ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         ALUop;
  logic [1:0]         ImmSrc;
  logic               illegal;
  logic [STATE_W-1:0] state;

  modport master (
    input  op, zero, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUop, ImmSrc, illegal, state
  );

  modport slave (
    output op, zero, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUop, ImmSrc, illegal, state
  );
endinterface

// File: rtl/multicycle_controller_op_decode.sv
// Opcode decode: immediate format, state after DECODE, and unsupported-opcode flag.
// MC_JAL_EN makes jal a legal instruction routed to the JAL state.
module mc_op_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] imm_src,
  output state_t     dec_next,
  output logic       op_illegal
);

  always_comb begin
    imm_src    = IMM_I;
    dec_next   = S_FETCH;
    op_illegal = 1'b1;
    case (op)
      OP_LW: begin
        dec_next   = S_MEMADR;
        op_illegal = 1'b0;
      end
      OP_SW: begin
        imm_src    = IMM_S;
        dec_next   = S_MEMADR;
        op_illegal = 1'b0;
      end
      OP_RTYPE: begin
        dec_next   = S_EXECR;
        op_illegal = 1'b0;
      end
      OP_ITYPE: begin
        dec_next   = S_EXECI;
        op_illegal = 1'b0;
      end
      OP_BEQ: begin
        imm_src    = IMM_B;
        dec_next   = S_BEQ;
        op_illegal = 1'b0;
      end
      OP_JAL: begin
        // J-format is reported even when jal itself is not supported
        imm_src = IMM_J;
`ifdef MC_JAL_EN
        dec_next   = S_JAL;
        op_illegal = 1'b0;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing a shared-memory multi-cycle RISC-V datapath with memory wait states.
// Optional jal support is enabled with MC_JAL_EN.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  multicycle_controller_if.master bus
);

  state_t     cur, nxt;
  state_t     dec_next;
  logic [1:0] imm_src;
  logic       op_illegal;

  logic pc_update, branch, mem_write, ir_write, reg_write, ill;
  logic adr_src;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;

  mc_op_decode u_dec (
    .op         (bus.op),
    .imm_src    (imm_src),
    .dec_next   (dec_next),
    .op_illegal (op_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) cur <= S_FETCH;
    else     cur <= nxt;
  end

  always_comb begin
    nxt = S_FETCH;
    case (cur)
      S_FETCH:    nxt = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:   nxt = dec_next;
      S_MEMADR:   nxt = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  nxt = bus.mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    nxt = S_FETCH;
      S_MEMWRITE: nxt = bus.mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    nxt = S_ALUWB;
      S_EXECI:    nxt = S_ALUWB;
      S_ALUWB:    nxt = S_FETCH;
      S_BEQ:      nxt = S_FETCH;
`ifdef MC_JAL_EN
      S_JAL:      nxt = S_ALUWB;
`endif
      default:    nxt = S_FETCH;
    endcase
  end

  always_comb begin
    pc_update  = 1'b0;
    branch     = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    ill        = 1'b0;
    adr_src    = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALU_ADD;
    case (cur)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write   = bus.mem_ready;
        pc_update  = bus.mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        ill       = op_illegal;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src = RES_READDATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_FUNCT;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BEQ: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_SUB;
        branch    = 1'b1;
      end
`ifdef MC_JAL_EN
      // PC takes the DECODE-computed target from ALUOut while the ALU forms OldPC+4 for rd
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign bus.PCWrite   = ~rst & (pc_update | (branch & bus.zero));
  assign bus.MemWrite  = ~rst & mem_write;
  assign bus.IRWrite   = ~rst & ir_write;
  assign bus.RegWrite  = ~rst & reg_write;
  assign bus.illegal   = ~rst & ill;
  assign bus.AdrSrc    = adr_src;
  assign bus.ResultSrc = result_src;
  assign bus.ALUSrcA   = alu_src_a;
  assign bus.ALUSrcB   = alu_src_b;
  assign bus.ALUop     = alu_op;
  assign bus.ImmSrc    = imm_src;
  assign bus.state     = STATE_W'(cur);

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction step-sequence model checked every cycle, plus directed literal checks.
module tb_multicycle_controller;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111, BAD = 7'b1111111;
`ifdef MC_JAL_EN
  localparam bit JAL_EN = 1'b1;
`else
  localparam bit JAL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_controller_if #(.STATE_W(4)) ifc ();
  multicycle_controller #(.STATE_W(4)) dut (.clk(clk), .rst(rst), .bus(ifc.master));

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Instruction latency with memory always ready; a 2-step path means DECODE rejects the opcode.
  function automatic int path_len(input logic [6:0] o);
    case (o)
      LW:      return 5;
      SW:      return 4;
      RT, IT:  return 4;
      BQ:      return 3;
      JL:      return JAL_EN ? 4 : 2;
      default: return 2;
    endcase
  endfunction

  function automatic int path_at(input logic [6:0] o, input int i);
    if (i == 0) return 0;
    if (i == 1) return 1;
    case (o)
      LW:      return (i == 2) ? 2 : (i == 3) ? 3 : 4;
      SW:      return (i == 2) ? 2 : 5;
      RT:      return (i == 2) ? 6 : 7;
      IT:      return (i == 2) ? 8 : 7;
      BQ:      return 10;
      JL:      return (i == 2) ? 9 : 7;
      default: return 0;
    endcase
  endfunction

  function automatic int exp_vec(input int st, input logic [6:0] o, input logic z, input logic mr,
                                 input logic r);
    logic pcu, br, adr, mw, irw, rw, ill;
    logic [1:0] rs, sa, sb, alu, imm;
    {pcu, br, adr, mw, irw, rw, ill} = '0;
    {rs, sa, sb, alu, imm} = '0;
    case (st)
      0:  begin sb = 2; rs = 2; irw = mr; pcu = mr; end
      1:  begin sa = 1; sb = 1; ill = (path_len(o) == 2); end
      2:  begin sa = 2; sb = 1; end
      3:  adr = 1;
      4:  begin rs = 1; rw = 1; end
      5:  begin adr = 1; mw = 1; end
      6:  begin sa = 2; alu = 2; end
      7:  rw = 1;
      8:  begin sa = 2; sb = 1; alu = 2; end
      9:  begin sa = 1; sb = 2; pcu = 1; end
      10: begin sa = 2; alu = 1; br = 1; end
      default: ;
    endcase
    case (o)
      SW: imm = 1;
      BQ: imm = 2;
      JL: imm = 3;
      default: imm = 0;
    endcase
    if (r) {pcu, br, mw, irw, rw, ill} = '0;
    return int'({pcu | (br & z), adr, mw, irw, rw, rs, sa, sb, alu, imm, ill, 4'(st)});
  endfunction

  logic [19:0] dut_vec;
  assign dut_vec = {ifc.PCWrite, ifc.AdrSrc, ifc.MemWrite, ifc.IRWrite, ifc.RegWrite, ifc.ResultSrc,
                    ifc.ALUSrcA, ifc.ALUSrcB, ifc.ALUop, ifc.ImmSrc, ifc.illegal, ifc.state};

  int         midx = 0;
  logic [6:0] mop = '0;
  bit         started = 1'b0;
  int         m_st;
  always_comb m_st = path_at(mop, midx);

  always @(posedge clk) begin
    started <= 1'b1;
    if (midx == 0) mop <= ifc.op;
    if (rst) midx <= 0;
    else if ((m_st == 0 || m_st == 3 || m_st == 5) && !ifc.mem_ready) midx <= midx;
    else if (midx + 1 >= path_len((midx == 0) ? ifc.op : mop)) midx <= 0;
    else midx <= midx + 1;
  end

  always @(negedge clk)
    if (started)
      chk("cycle_outputs", int'(dut_vec), exp_vec(m_st, ifc.op, ifc.zero, ifc.mem_ready, rst));

  int cap_state, cap_pcw, cap_irw, cap_mw, cap_rw, cap_rs, cap_alu, cap_imm, cap_ill;

  task automatic tick;
    @(negedge clk);
    cap_state = int'(ifc.state);
    cap_pcw   = int'(ifc.PCWrite);
    cap_irw   = int'(ifc.IRWrite);
    cap_mw    = int'(ifc.MemWrite);
    cap_rw    = int'(ifc.RegWrite);
    cap_rs    = int'(ifc.ResultSrc);
    cap_alu   = int'(ifc.ALUop);
    cap_imm   = int'(ifc.ImmSrc);
    cap_ill   = int'(ifc.illegal);
    @(posedge clk);
    #1;
  endtask

  task automatic run_path(input string nm, input int n, input int exp_states[6]);
    for (int i = 0; i < n; i++) begin
      tick();
      chk(nm, cap_state, exp_states[i]);
    end
  endtask

  int seq[6];
  int cnt;

  initial begin
    rst = 1'b1; ifc.op = LW; ifc.zero = 1'b0; ifc.mem_ready = 1'b1;
    tick(); tick();
    chk("reset_state", cap_state, 0);
    rst = 1'b0; ifc.mem_ready = 1'b0;
    tick();
    chk("idle_state", cap_state, 0);

    // lw
    ifc.mem_ready = 1'b1; ifc.op = LW;
    for (int i = 0; i < 5; i++) begin
      tick();
      seq[i] = cap_state;
      if (i == 3) chk("lw_regwrite_memread", cap_rw, 0);
      if (i == 4) begin
        chk("lw_regwrite_wb", cap_rw, 1);
        chk("lw_resultsrc_wb", cap_rs, 1);
        chk("lw_immsrc", cap_imm, 0);
      end
    end
    ifc.mem_ready = 1'b0;
    tick();
    seq[5] = cap_state;
    chk("lw_s0", seq[0], 0); chk("lw_s1", seq[1], 1); chk("lw_s2", seq[2], 2);
    chk("lw_s3", seq[3], 3); chk("lw_s4", seq[4], 4); chk("lw_s5", seq[5], 0);

    // sw with three wait cycles in MEMWRITE
    ifc.mem_ready = 1'b1; ifc.op = SW;
    run_path("sw_state", 3, '{0, 1, 2, 0, 0, 0});
    chk("sw_immsrc", cap_imm, 1);
    ifc.mem_ready = 1'b0;
    cnt = 0;
    repeat (3) begin tick(); cnt += cap_mw; end
    ifc.mem_ready = 1'b1;
    tick(); cnt += cap_mw;
    chk("sw_memwrite_cycles", cnt, 4);
    ifc.mem_ready = 1'b0;
    tick();
    chk("sw_end_state", cap_state, 0);
    chk("sw_end_memwrite", cap_mw, 0);

    // beq taken / not taken
    for (int z = 1; z >= 0; z--) begin
      ifc.mem_ready = 1'b1; ifc.op = BQ; ifc.zero = z[0];
      run_path("beq_state", 3, '{0, 1, 10, 0, 0, 0});
      chk("beq_pcwrite", cap_pcw, z);
      chk("beq_aluop", cap_alu, 1);
      chk("beq_immsrc", cap_imm, 2);
      ifc.mem_ready = 1'b0;
      tick();
      chk("beq_end_state", cap_state, 0);
    end
    ifc.zero = 1'b0;

    // FETCH stall then R-type
    ifc.op = RT;
    repeat (2) begin
      tick();
      chk("stall_state", cap_state, 0);
      chk("stall_irwrite", cap_irw, 0);
      chk("stall_pcwrite", cap_pcw, 0);
    end
    ifc.mem_ready = 1'b1;
    tick();
    chk("fetch_irwrite", cap_irw, 1);
    chk("fetch_pcwrite", cap_pcw, 1);
    run_path("rtype_state", 3, '{1, 6, 7, 0, 0, 0});
    chk("rtype_regwrite", cap_rw, 1);
    ifc.mem_ready = 1'b0;
    tick();

    // I-type
    ifc.mem_ready = 1'b1; ifc.op = IT;
    run_path("itype_state", 4, '{0, 1, 8, 7, 0, 0});
    ifc.mem_ready = 1'b0;
    tick();

    // unsupported opcode
    ifc.mem_ready = 1'b1; ifc.op = BAD;
    tick();
    chk("bad_fetch_illegal", cap_ill, 0);
    tick();
    chk("bad_decode_state", cap_state, 1);
    chk("bad_decode_illegal", cap_ill, 1);
    ifc.mem_ready = 1'b0;
    tick();
    chk("bad_next_state", cap_state, 0);
    chk("bad_next_illegal", cap_ill, 0);

    // jal
    ifc.mem_ready = 1'b1; ifc.op = JL;
    run_path("jal_state", 2, '{0, 1, 0, 0, 0, 0});
    chk("jal_immsrc", cap_imm, 3);
    chk("jal_decode_illegal", cap_ill, JAL_EN ? 0 : 1);
    if (JAL_EN) begin
      tick();
      chk("jal_state9", cap_state, 9);
      chk("jal_pcwrite", cap_pcw, 1);
      tick();
      chk("jal_state7", cap_state, 7);
    end
    ifc.mem_ready = 1'b0;
    tick();
    chk("jal_end_state", cap_state, 0);

    // reset in the middle of MEMWRITE
    ifc.mem_ready = 1'b1; ifc.op = SW;
    run_path("rstsw_state", 3, '{0, 1, 2, 0, 0, 0});
    ifc.mem_ready = 1'b0;
    tick();
    chk("rstsw_memwrite_before", cap_mw, 1);
    rst = 1'b1;
    tick();
    chk("rstsw_memwrite_in_reset", cap_mw, 0);
    tick();
    chk("rstsw_state_in_reset", cap_state, 0);
    chk("rstsw_memwrite_in_reset2", cap_mw, 0);
    rst = 1'b0; ifc.mem_ready = 1'b1;
    tick();
    chk("rstsw_post_state", cap_state, 0);
    chk("rstsw_post_irwrite", cap_irw, 1);
    chk("rstsw_post_pcwrite", cap_pcw, 1);
    tick();
    chk("rstsw_post_decode", cap_state, 1);
    ifc.mem_ready = 1'b0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
